// File: rtl/tt_aes_byte_bridge.sv
// Byte-serial command bridge: collects a command, address and optional write data
// from an 8-bit stream, performs one bus access, and streams read data back MSB first.
module tt_aes_byte_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err,
    output logic              cs,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam int ADDR_BYTES = ADDR_W / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES) + 1;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        ISSUE = 3'd3,
        RDOUT = 3'd4
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                we_flag_reg;
    logic [DATA_W-1:0]   rd_shift_reg;
    logic [ADDR_W-1:0]   address_next;
    logic [DATA_W-1:0]   write_data_next;

    // Byte-lane shifters: the new byte enters lane 0, every other lane takes its lower neighbour.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr_lane
            if (gi == 0) begin : g_low
                assign address_next[7:0] = in_data;
            end else begin : g_up
                assign address_next[gi*8 +: 8] = address[(gi-1)*8 +: 8];
            end
        end
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_wdata_lane
            if (gi == 0) begin : g_low
                assign write_data_next[7:0] = in_data;
            end else begin : g_up
                assign write_data_next[gi*8 +: 8] = write_data[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    assign in_ready = !rst && (state_reg == IDLE || state_reg == ADDR || state_reg == WDATA);
    assign out_data = rd_shift_reg[DATA_W-1 -: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            we_flag_reg  <= 1'b0;
            rd_shift_reg <= '0;
            cs           <= 1'b0;
            we           <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            err          <= 1'b0;
            address      <= '0;
            write_data   <= '0;
        end else begin
            cs <= 1'b0;
            we <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (in_data[6:0] != 7'd0) begin
                            err <= 1'b1;
                        end else begin
                            we_flag_reg <= in_data[7];
                            cnt_reg     <= '0;
                            busy        <= 1'b1;
                            state_reg   <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (in_valid) begin
                        address <= address_next;
                        if (cnt_reg == ADDR_LAST) begin
                            cnt_reg <= '0;
                            if (we_flag_reg) begin
                                state_reg <= WDATA;
                            end else begin
                                state_reg <= ISSUE;
                                cs        <= 1'b1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                WDATA: begin
                    if (in_valid) begin
                        write_data <= write_data_next;
                        if (cnt_reg == DATA_LAST) begin
                            cnt_reg   <= '0;
                            state_reg <= ISSUE;
                            cs        <= 1'b1;
                            we        <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    cnt_reg <= '0;
                    if (we_flag_reg) begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        rd_shift_reg <= read_data;
                        out_valid    <= 1'b1;
                        state_reg    <= RDOUT;
                    end
                end
                RDOUT: begin
                    if (out_ready) begin
                        rd_shift_reg <= rd_shift_reg << 8;
                        if (cnt_reg == DATA_LAST) begin
                            cnt_reg   <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_aes_byte_bridge.sv
// Random command stream against a word-addressed memory model; a second instance
// covers the wide-bus parameterisation.
module tb_tt_aes_byte_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy, err, cs, we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    logic [7:0]  in_data2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic        busy2, err2, cs2, we2;
    logic [15:0] address2;
    logic [63:0] write_data2;
    logic [63:0] read_data2;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cs_cnt   = 0;
    int cs2_cnt  = 0;
    logic err_exp = 1'b0;

    logic [31:0] slave_mem [0:255];
    logic [31:0] ref_mem   [0:255];

    always #5 clk = ~clk;

    tt_aes_byte_bridge #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err(err), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    tt_aes_byte_bridge #(.ADDR_W(16), .DATA_W(64)) dut_wide (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .err(err2), .cs(cs2), .we(we2), .address(address2),
        .write_data(write_data2), .read_data(read_data2)
    );

    // Bus slave: only returns real data while cs is asserted.
    assign read_data  = cs ? slave_mem[address] : 32'hBAD0_BAD0;
    assign read_data2 = cs2 ? 64'h0011_2233_4455_6677 : 64'hFFFF_0000_FFFF_0000;

    always @(posedge clk) begin
        if (cs && we) slave_mem[address] <= write_data;
    end

    always @(negedge clk) begin
        if (cs)  cs_cnt  = cs_cnt + 1;
        if (cs2) cs2_cnt = cs2_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_data2  = b;
        in_valid2 = 1'b1;
        n = 0;
        while (!in_ready2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_val("in_ready2_timeout", 64'(in_ready2), 64'd1);
        @(posedge clk);
        #1 in_valid2 = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        int c0;
        c0 = cs_cnt;
        send_byte(8'h80);
        send_byte(a);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
        check_val("wr_cs", 64'(cs), 64'd1);
        check_val("wr_we", 64'(we), 64'd1);
        check_val("wr_addr", 64'(address), 64'(a));
        check_val("wr_data", 64'(write_data), 64'(d));
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        check_val("wr_cs_end", 64'(cs), 64'd0);
        check_val("wr_busy_end", 64'(busy), 64'd0);
        check_val("wr_cs_count", 64'(cs_cnt - c0), 64'd1);
        check_val("wr_err", 64'(err), 64'(err_exp));
        $display("write addr=%02h data=%08h", a, d);
    endtask

    task automatic do_read(input logic [7:0] a, input int stall_at, input int stall_n);
        int c0;
        logic [7:0] exp_b;
        c0 = cs_cnt;
        send_byte(8'h00);
        send_byte(a);
        check_val("rd_cs", 64'(cs), 64'd1);
        check_val("rd_we", 64'(we), 64'd0);
        check_val("rd_addr", 64'(address), 64'(a));
        @(posedge clk);
        #1;
        check_val("rd_cs_end", 64'(cs), 64'd0);
        for (int i = 0; i < 4; i++) begin
            exp_b = ref_mem[a][31 - 8*i -: 8];
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    check_val("rd_hold_valid", 64'(out_valid), 64'd1);
                    check_val("rd_hold_data", 64'(out_data), 64'(exp_b));
                    @(posedge clk);
                    #1;
                end
            end
            check_val("rd_valid", 64'(out_valid), 64'd1);
            check_val("rd_byte", 64'(out_data), 64'(exp_b));
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        check_val("rd_valid_end", 64'(out_valid), 64'd0);
        check_val("rd_busy_end", 64'(busy), 64'd0);
        check_val("rd_in_ready_end", 64'(in_ready), 64'd1);
        check_val("rd_cs_count", 64'(cs_cnt - c0), 64'd1);
        $display("read  addr=%02h data=%08h", a, ref_mem[a]);
    endtask

    task automatic bad_cmd(input logic [7:0] c);
        int c0;
        c0 = cs_cnt;
        send_byte(c);
        err_exp = 1'b1;
        check_val("bad_err", 64'(err), 64'd1);
        check_val("bad_busy", 64'(busy), 64'd0);
        check_val("bad_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check_val("bad_cs_count", 64'(cs_cnt - c0), 64'd0);
        $display("bad   cmd=%02h", c);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd;
        logic [7:0]  got2 [$];
        int c0;
        int r;

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        rst = 1'b1;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        in_data2 = 8'h00; in_valid2 = 1'b0; out_ready2 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_in_ready2", 64'(in_ready2), 64'd0);
        check_val("rst_cs", 64'(cs), 64'd0);
        check_val("rst_we", 64'(we), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_out_data", 64'(out_data), 64'd0);
        check_val("rst_address", 64'(address), 64'd0);
        check_val("rst_write_data", 64'(write_data), 64'd0);
        rst = 1'b0;

        // Directed cases from the datasheet examples.
        do_write(8'h10, 32'h0123_4567);
        slave_mem[8'h08] = 32'hDEAD_BEEF;
        ref_mem[8'h08]   = 32'hDEAD_BEEF;
        do_read(8'h08, 4, 0);
        do_read(8'h08, 1, 5);
        bad_cmd(8'h41);
        do_write(8'h10, 32'h0123_4567);

        // Reset in the middle of a write command.
        c0 = cs_cnt;
        send_byte(8'h80);
        send_byte(8'h10);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_err", 64'(err), 64'd0);
        check_val("mid_rst_cs", 64'(cs), 64'd0);
        check_val("mid_rst_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        err_exp = 1'b0;
        check_val("mid_rst_cs_count", 64'(cs_cnt - c0), 64'd0);
        $display("reset during write data");
        do_write(8'h10, 32'h0123_4567);
        do_read(8'h10, 0, 2);

        // Randomised command mix.
        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 9);
            ra = 8'($urandom);
            rd = $urandom;
            if (r < 4) do_write(ra, rd);
            else if (r < 9) do_read(ra, $urandom_range(0, 4), $urandom_range(0, 3));
            else bad_cmd({1'($urandom), 7'($urandom_range(1, 127))});
        end

        // Wide-bus instance.
        c0 = cs2_cnt;
        send2(8'h80);
        send2(8'h12);
        send2(8'h34);
        for (int i = 0; i < 8; i++) send2(8'(i));
        check_val("wide_cs", 64'(cs2), 64'd1);
        check_val("wide_we", 64'(we2), 64'd1);
        check_val("wide_addr", 64'(address2), 64'h1234);
        check_val("wide_data", write_data2, 64'h0001_0203_0405_0607);
        $display("wide write addr=%04h data=%016h", address2, write_data2);
        send2(8'h00);
        send2(8'h56);
        send2(8'h78);
        check_val("wide_rd_addr", 64'(address2), 64'h5678);
        check_val("wide_rd_we", 64'(we2), 64'd0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid2) got2.push_back(out_data2);
        end
        check_val("wide_rd_len", 64'(got2.size()), 64'd8);
        for (int i = 0; i < 8 && i < got2.size(); i++)
            check_val("wide_rd_byte", 64'(got2[i]), 64'(8'h11 * i));
        check_val("wide_busy_end", 64'(busy2), 64'd0);
        check_val("wide_cs_count", 64'(cs2_cnt - c0), 64'd2);
        $display("wide read addr=5678 bytes=%0d", got2.size());

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
